vram_writer: RTL and testbench

VRAM_WRITER -- requirements
Module: vram_writer

---
 rtl/vram_writer.sv | 178 +++++++++++++++++
 tb/tb_vram_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// Z80-to-video-RAM write bridge: synchronises CPU bus writes into a small queue,
// drives the VRAM write port, handles border OUTs and a hardware screen fill.
module vram_writer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        wr_n,
    input  logic        clr_req,
    input  logic [7:0]  clr_pix,
    input  logic [7:0]  clr_attr,
    output logic [12:0] aw,
    output logic [7:0]  di,
    output logic        we,
    output logic [2:0]  border,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [12:0] LAST_ADDR = 13'h1AFF;
    localparam logic [12:0] ATTR_BASE = 13'h1800;
    localparam logic [12:0] SCR_END   = 13'h1B00;

    typedef enum logic {StIdle, StFill} state_e;

    state_e       r_state;
    state_e       w_state_next;

    logic [15:0]  r_a_s1, r_a_s2;
    logic [7:0]   r_d_s1, r_d_s2;
    logic         r_mreq_s1, r_mreq_s2;
    logic         r_iorq_s1, r_iorq_s2;
    logic         r_wr_s1, r_wr_s2;
    logic         r_mwr_prev, r_iowr_prev;

    logic [20:0]  r_mem [FIFO_DEPTH];
    logic [PW:0]  r_wptr, r_rptr;
    logic [12:0]  r_cnt;
    logic [12:0]  r_aw_q;
    logic [7:0]   r_di_q;
    logic [2:0]   r_border;
    logic         r_ovf;

    logic         w_mwr, w_iowr, w_mwr_ev, w_iowr_ev, w_addr_ok;
    logic         w_empty, w_full, w_flush, w_pop, w_push_req, w_push, w_drop;
    logic [20:0]  w_head;

    // Strobe flops reset to the inactive (high) level so release never fakes an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a_s1      <= '0;
            r_a_s2      <= '0;
            r_d_s1      <= '0;
            r_d_s2      <= '0;
            r_mreq_s1   <= 1'b1;
            r_mreq_s2   <= 1'b1;
            r_iorq_s1   <= 1'b1;
            r_iorq_s2   <= 1'b1;
            r_wr_s1     <= 1'b1;
            r_wr_s2     <= 1'b1;
            r_mwr_prev  <= 1'b0;
            r_iowr_prev <= 1'b0;
        end else begin
            r_a_s1      <= a;
            r_a_s2      <= r_a_s1;
            r_d_s1      <= d;
            r_d_s2      <= r_d_s1;
            r_mreq_s1   <= mreq_n;
            r_mreq_s2   <= r_mreq_s1;
            r_iorq_s1   <= iorq_n;
            r_iorq_s2   <= r_iorq_s1;
            r_wr_s1     <= wr_n;
            r_wr_s2     <= r_wr_s1;
            r_mwr_prev  <= w_mwr;
            r_iowr_prev <= w_iowr;
        end
    end

    assign w_mwr      = ~r_mreq_s2 & ~r_wr_s2;
    assign w_iowr     = ~r_iorq_s2 & ~r_wr_s2;
    assign w_mwr_ev   = w_mwr & ~r_mwr_prev;
    assign w_iowr_ev  = w_iowr & ~r_iowr_prev;
    assign w_addr_ok  = (r_a_s2[15:13] == 3'b010) && (r_a_s2[12:0] < SCR_END);
    assign w_push_req = w_mwr_ev & w_addr_ok;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_head  = r_mem[r_rptr[PW-1:0]];

    // A clear request in IDLE discards the queue, so nothing pops that cycle.
    assign w_flush = (r_state == StIdle) & clr_req;
    assign w_pop   = (r_state == StIdle) & ~w_empty & ~clr_req;
    assign w_push  = w_push_req & ~w_flush & (~w_full | w_pop);
    assign w_drop  = w_push_req & ~w_flush & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[PW-1:0]] <= {r_a_s2[12:0], r_d_s2};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ovf    <= 1'b0;
            r_border <= '0;
            r_cnt    <= '0;
            r_aw_q   <= '0;
            r_di_q   <= '0;
        end else begin
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) r_ovf <= 1'b1;
            if (w_iowr_ev && !r_a_s2[0]) r_border <= r_d_s2[2:0];
            if (w_flush) begin
                r_cnt <= '0;
            end else if (r_state == StFill) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (we) begin
                r_aw_q <= aw;
                r_di_q <= di;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (clr_req) w_state_next = StFill;
            StFill:  if (r_cnt == LAST_ADDR) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        we   = 1'b0;
        busy = 1'b0;
        aw   = r_aw_q;
        di   = r_di_q;
        case (r_state)
            StFill: begin
                busy = 1'b1;
                we   = 1'b1;
                aw   = r_cnt;
                di   = (r_cnt < ATTR_BASE) ? clr_pix : clr_attr;
            end
            StIdle: begin
                if (w_pop) begin
                    we = 1'b1;
                    aw = w_head[20:8];
                    di = w_head[7:0];
                end
            end
            default: ;
        endcase
    end

    assign border = r_border;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: every VRAM write is checked against a queue of
// expected {aw, di} pairs filled as stimulus is driven.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] a;
    logic [7:0]  d;
    logic        mreq_n, iorq_n, wr_n;
    logic        clr_req;
    logic [7:0]  clr_pix, clr_attr;
    logic [12:0] aw;
    logic [7:0]  di;
    logic        we;
    logic [2:0]  border;
    logic        busy, ovf;

    logic [20:0] sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    vram_writer #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .a        (a),
        .d        (d),
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .wr_n     (wr_n),
        .clr_req  (clr_req),
        .clr_pix  (clr_pix),
        .clr_attr (clr_attr),
        .aw       (aw),
        .di       (di),
        .we       (we),
        .border   (border),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample on the falling edge and score any write against the queue.
    task automatic cyc();
        logic [20:0] e;
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        if (we === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_we: observed aw=%h di=%h expected no write", aw, di);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                assert ({aw, di} === e) else begin
                    errors++;
                    $error("FAIL write_data: observed aw=%h di=%h expected aw=%h di=%h",
                           aw, di, e[20:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic mem_write(input logic [15:0] addr, input logic [7:0] data, input bit exp);
        a = addr;
        d = data;
        cyc();
        if (exp) sb.push_back({addr[12:0], data});
        mreq_n = 1'b0;
        wr_n   = 1'b0;
        repeat (4) cyc();
        mreq_n = 1'b1;
        wr_n   = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic io_write(input logic [15:0] port, input logic [7:0] data);
        a = port;
        d = data;
        cyc();
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        repeat (4) cyc();
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic start_fill(input logic [7:0] pix, input logic [7:0] attr);
        logic [12:0] ai;
        clr_pix  = pix;
        clr_attr = attr;
        for (int i = 0; i < 6912; i++) begin
            ai = 13'(i);
            sb.push_back({ai, (i < 'h1800) ? pix : attr});
        end
        busy_cnt = 0;
        clr_req  = 1'b1;
        cyc();
        clr_req  = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy === 1'b1 && g < 8000) begin
            cyc();
            g++;
        end
        chk("fill_end_timeout", 32'(g < 8000), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        a        = '0;
        d        = '0;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        wr_n     = 1'b1;
        clr_req  = 1'b0;
        clr_pix  = '0;
        clr_attr = '0;
        repeat (3) cyc();
        chk("rst_we", we, 0);
        chk("rst_aw", aw, 0);
        chk("rst_di", di, 0);
        chk("rst_border", border, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        resetn = 1'b1;
        repeat (3) cyc();

        // Single write: we exactly one cycle after the synchronised edge.
        a = 16'h4000;
        d = 8'hAA;
        cyc();
        sb.push_back({13'h0000, 8'hAA});
        mreq_n = 1'b0;
        wr_n   = 1'b0;
        cyc();
        cyc();
        chk("mwr_not_early", we, 0);
        cyc();
        chk("mwr_latency_we", we, 1);
        chk("mwr_aw", aw, 13'h0000);
        chk("mwr_di", di, 8'hAA);
        repeat (3) cyc();
        mreq_n = 1'b1;
        wr_n   = 1'b1;
        repeat (3) cyc();
        chk("hold_aw", aw, 13'h0000);
        chk("hold_di", di, 8'hAA);

        mem_write(16'h3FFF, 8'h11, 1'b0);
        mem_write(16'h5B00, 8'h22, 1'b0);
        mem_write(16'hC000, 8'h33, 1'b0);
        mem_write(16'h5AFF, 8'h38, 1'b1);
        chk("addr_window_drained", sb.size(), 0);

        io_write(16'h00FE, 8'h05);
        chk("border_fe", border, 3'b101);
        io_write(16'h00FF, 8'h02);
        chk("border_ff_ignored", border, 3'b101);
        io_write(16'h12FE, 8'hFA);
        chk("border_fe_hi", border, 3'b010);

        // Plain screen fill.
        start_fill(8'h00, 8'h38);
        wait_idle();
        chk("fill_busy_cycles", busy_cnt, 6912);
        chk("fill_drained", sb.size(), 0);
        repeat (3) cyc();

        // Fill with a CPU write and an ignored clr_req in the middle.
        start_fill(8'h55, 8'hAA);
        repeat (100) cyc();
        mem_write(16'h5800, 8'h47, 1'b1);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        wait_idle();
        chk("midfill_busy_cycles", busy_cnt, 6912);
        chk("midfill_we", we, 1);
        chk("midfill_aw", aw, 13'h1800);
        chk("midfill_di", di, 8'h47);
        repeat (3) cyc();
        chk("midfill_drained", sb.size(), 0);

        // Overflow: FIFO_DEPTH + 1 writes queued during a fill.
        start_fill(8'hFF, 8'h00);
        repeat (10) cyc();
        chk("ovf_before", ovf, 0);
        for (int i = 0; i < 5; i++) begin
            mem_write(16'h4100 + 16'(i), 8'h10 + 8'(i), i < 4);
        end
        chk("ovf_set", ovf, 1);
        wait_idle();
        repeat (8) cyc();
        chk("ovf_drained", sb.size(), 0);
        chk("ovf_sticky", ovf, 1);
        resetn = 1'b0;
        #1;
        chk("ovf_cleared_by_reset", ovf, 0);
        chk("border_cleared_by_reset", border, 0);
        repeat (2) cyc();
        resetn = 1'b1;
        repeat (3) cyc();

        // Reset mid-fill aborts with no further write.
        start_fill(8'h12, 8'h34);
        repeat (50) cyc();
        resetn = 1'b0;
        #1;
        chk("abort_we", we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_aw", aw, 0);
        chk("abort_di", di, 0);
        sb.delete();
        repeat (3) cyc();
        resetn = 1'b1;
        repeat (10) cyc();
        chk("after_abort_busy", busy, 0);
        mem_write(16'h4ABC, 8'h5A, 1'b1);
        chk("after_abort_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
